// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit owning HI/LO: multu/div/divu take 32 cycles, mthi/mtlo
// write in the accepting cycle, and mul_res is the combinational low word of a*b.
module mdu_iter #(
  parameter int unsigned ITER = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  mdu_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] mul_res,
  output logic [31:0] high,
  output logic [31:0] low,
  output logic        busy,
  output logic        done
);

  localparam logic [2:0] OpMultu = 3'd2;
  localparam logic [2:0] OpDiv   = 3'd3;
  localparam logic [2:0] OpDivu  = 3'd4;
  localparam logic [2:0] OpMthi  = 3'd5;
  localparam logic [2:0] OpMtlo  = 3'd6;

  typedef enum logic [0:0] {StIdle, StCalc} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        is_mul_q, is_mul_d;
  logic        neg_quot_q, neg_quot_d;
  logic        neg_rem_q, neg_rem_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] opb_q, opb_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  logic        accept, accept_iter, last;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum;
  logic [32:0] div_shift, div_diff;
  logic [63:0] mul_next, div_next, iter_next;
  logic [31:0] quot_fix, rem_fix;

  assign mul_res     = a * b;
  assign accept      = (state_q == StIdle) && start && (mdu_op >= OpMultu) && (mdu_op <= OpMtlo);
  assign accept_iter = accept && (mdu_op <= OpDivu);
  assign last        = (cnt_q == 5'(ITER - 1));
  assign a_mag       = a[31] ? (~a + 32'd1) : a;
  assign b_mag       = b[31] ? (~b + 32'd1) : b;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept_iter) state_d = StCalc;
      StCalc: if (last) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    busy = (state_q == StCalc);
    done = done_q;
    high = hi_q;
    low  = lo_q;
  end

  // Datapath: acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
    mul_next  = {mul_sum, acc_q[31:1]};
    div_shift = {acc_q[63:32], acc_q[31]};
    div_diff  = div_shift - {1'b0, opb_q};
    div_next  = div_diff[32] ? {div_shift[31:0], acc_q[30:0], 1'b0}
                             : {div_diff[31:0], acc_q[30:0], 1'b1};
    iter_next = is_mul_q ? mul_next : div_next;

    quot_fix = neg_quot_q ? (~iter_next[31:0] + 32'd1) : iter_next[31:0];
    rem_fix  = neg_rem_q ? (~iter_next[63:32] + 32'd1) : iter_next[63:32];
    // Remainder path already reproduces a on divide-by-zero; only the quotient is forced
    if (opb_q == 32'd0) quot_fix = '1;
  end

  always_comb begin
    cnt_d      = cnt_q;
    is_mul_d   = is_mul_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    acc_d      = acc_q;
    opb_d      = opb_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;

    if (state_q == StIdle) begin
      if (accept) begin
        cnt_d = '0;
        unique case (mdu_op)
          OpMultu, OpDivu: begin
            is_mul_d   = (mdu_op == OpMultu);
            neg_quot_d = 1'b0;
            neg_rem_d  = 1'b0;
            acc_d      = {32'd0, a};
            opb_d      = b;
          end
          OpDiv: begin
            is_mul_d   = 1'b0;
            neg_quot_d = a[31] ^ b[31];
            neg_rem_d  = a[31];
            acc_d      = {32'd0, a_mag};
            opb_d      = b_mag;
          end
          OpMthi: begin
            hi_d   = a;
            done_d = 1'b1;
          end
          OpMtlo: begin
            lo_d   = a;
            done_d = 1'b1;
          end
          default: ;
        endcase
      end
    end else begin
      acc_d = iter_next;
      cnt_d = cnt_q + 5'd1;
      if (last) begin
        cnt_d  = '0;
        done_d = 1'b1;
        if (is_mul_q) begin
          hi_d = iter_next[63:32];
          lo_d = iter_next[31:0];
        end else begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      is_mul_q   <= 1'b0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      acc_q      <= '0;
      opb_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      is_mul_q   <= is_mul_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      acc_q      <= acc_d;
      opb_q      <= opb_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed self-checking bench for mdu_iter with hand-computed HI/LO/mul_res expectations.
module tb_mdu_iter;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  mdu_op;
  logic [31:0] a, b;
  logic [31:0] mul_res, high, low;
  logic        busy, done;

  int checks   = 0;
  int failures = 0;
  logic [31:0] m_hi, m_lo;

  mdu_iter #(.ITER(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .mdu_op  (mdu_op),
    .a       (a),
    .b       (b),
    .mul_res (mul_res),
    .high    (high),
    .low     (low),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // disturb: 0 none, 1 mthi pulse plus operand change at busy cycle 10, 2 reset at cycle 10
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] opa,
                        input logic [31:0] opb, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input int disturb);
    int n;
    int done_in_busy;
    int dones;
    start  = 1'b1;
    mdu_op = op;
    a      = opa;
    b      = opb;
    tick();
    start  = 1'b0;
    mdu_op = 3'd0;
    n = 0;
    done_in_busy = 0;
    while (busy && n < 40) begin
      n++;
      if (done) done_in_busy++;
      if (n == 16) begin
        check_eq({tag, " hold_hi"}, {32'd0, high}, {32'd0, m_hi});
        check_eq({tag, " hold_lo"}, {32'd0, low}, {32'd0, m_lo});
      end
      if (n == 10 && disturb == 1) begin
        start  = 1'b1;
        mdu_op = 3'd5;
        a      = 32'h0000_DEAD;
        b      = 32'h0000_0003;
      end
      if (n == 11 && disturb == 1) begin
        start  = 1'b0;
        mdu_op = 3'd0;
      end
      if (n == 10 && disturb == 2) begin
        rst_n = 1'b0;
        #1;
        m_hi = 32'd0;
        m_lo = 32'd0;
        check_eq({tag, " rst_busy"}, {63'd0, busy}, 64'd0);
        check_eq({tag, " rst_hi"}, {32'd0, high}, 64'd0);
        check_eq({tag, " rst_lo"}, {32'd0, low}, 64'd0);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 30; i++) begin
          tick();
          if (done || busy) dones++;
        end
        check_eq({tag, " rst_no_done_busy"}, 64'(dones), 64'd0);
        return;
      end
      tick();
    end
    check_eq({tag, " busy_cycles"}, 64'(n), 64'd32);
    check_eq({tag, " done_in_busy"}, 64'(done_in_busy), 64'd0);
    check_eq({tag, " done"}, {63'd0, done}, 64'd1);
    check_eq({tag, " hi"}, {32'd0, high}, {32'd0, exp_hi});
    check_eq({tag, " lo"}, {32'd0, low}, {32'd0, exp_lo});
    m_hi = exp_hi;
    m_lo = exp_lo;
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    mdu_op = 3'd0;
    a      = 32'd0;
    b      = 32'd0;
    m_hi   = 32'd0;
    m_lo   = 32'd0;
    tick();
    tick();
    check_eq("reset busy", {63'd0, busy}, 64'd0);
    check_eq("reset done", {63'd0, done}, 64'd0);
    check_eq("reset hi", {32'd0, high}, 64'd0);
    check_eq("reset lo", {32'd0, low}, 64'd0);
    rst_n = 1'b1;
    tick();

    run_op("multu max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0);
    tick();
    check_eq("multu done_pulse_one", {63'd0, done}, 64'd0);

    // Back-to-back: each next op issues in the cycle done is high
    run_op("multu 2^32", 3'd2, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 0);
    run_op("multu 7x6", 3'd2, 32'd7, 32'd6, 32'd0, 32'd42, 0);
    run_op("div -7/2", 3'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
    run_op("div min/-1", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0);
    run_op("div 7/-2", 3'd3, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 0);
    run_op("divu 7/0", 3'd4, 32'd7, 32'd0, 32'h0000_0007, 32'hFFFF_FFFF, 0);
    run_op("div -16/0", 3'd3, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 0);
    run_op("divu big", 3'd4, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, 0);
    tick();

    // mthi then mtlo on consecutive cycles
    start  = 1'b1;
    mdu_op = 3'd5;
    a      = 32'h0000_1234;
    tick();
    check_eq("mthi done", {63'd0, done}, 64'd1);
    check_eq("mthi busy", {63'd0, busy}, 64'd0);
    check_eq("mthi hi", {32'd0, high}, 64'h0000_1234);
    mdu_op = 3'd6;
    a      = 32'hABCD_0000;
    tick();
    start  = 1'b0;
    mdu_op = 3'd0;
    check_eq("mtlo done", {63'd0, done}, 64'd1);
    check_eq("mtlo busy", {63'd0, busy}, 64'd0);
    check_eq("mtlo lo", {32'd0, low}, 64'hABCD_0000);
    check_eq("mtlo hi_kept", {32'd0, high}, 64'h0000_1234);
    tick();
    check_eq("mtlo done_drop", {63'd0, done}, 64'd0);
    m_hi = 32'h0000_1234;
    m_lo = 32'hABCD_0000;

    // Reserved and none opcodes are ignored
    for (int i = 0; i < 3; i++) begin
      start  = 1'b1;
      mdu_op = (i == 0) ? 3'd0 : ((i == 1) ? 3'd1 : 3'd7);
      a      = 32'h5555_5555;
      tick();
      check_eq("ignored busy", {63'd0, busy}, 64'd0);
      check_eq("ignored done", {63'd0, done}, 64'd0);
      check_eq("ignored hilo", {high, low}, {m_hi, m_lo});
    end
    start  = 1'b0;
    mdu_op = 3'd0;
    tick();

    run_op("divu 100/7 glitch", 3'd4, 32'd100, 32'd7, 32'd2, 32'd14, 1);
    tick();
    run_op("divu 100/7 reset", 3'd4, 32'd100, 32'd7, 32'd0, 32'd0, 2);

    // mul_res is combinational and leaves HI/LO alone
    a = 32'h1111_0000;
    b = 32'h0000_0005;
    tick();
    a = 32'hFFFF_FFFF;
    b = 32'd3;
    #1;
    check_eq("mul_res -1x3", {32'd0, mul_res}, 64'hFFFF_FFFD);
    a = 32'h0001_0000;
    b = 32'h0001_0001;
    #1;
    check_eq("mul_res wrap", {32'd0, mul_res}, 64'h0001_0000);
    tick();
    check_eq("mul_res hilo", {high, low}, {m_hi, m_lo});
    check_eq("mul_res busy", {63'd0, busy}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
